// File: rtl/score_event_arbiter.sv
// Round-robin arbiter turning per-source +1/-1 score events into one inc/dec pulse per clock.
// Optional feature macro SCORE_ARB_FLOOR_EN: consume dn grants silently while the score reads 0000.
module score_event_arbiter #(
  parameter int unsigned NSRC  = 4,
  parameter int unsigned CNT_W = 3,
  localparam int unsigned ID_W = (NSRC > 1) ? $clog2(NSRC) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic            flush,
  input  logic [NSRC-1:0] hit_up,
  input  logic [NSRC-1:0] hit_dn,
  input  logic            score_zero,
  input  logic            clr_ovf,
  output logic            inc,
  output logic            dec,
  output logic [ID_W-1:0] grant_id,
  output logic            pending_any,
  output logic            overflow
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   rr_q, rr_d;
  logic [ID_W-1:0]   gid_q, gid_d;
  logic              inc_q, inc_d;
  logic              dec_q, dec_d;
  logic              ovf_q, ovf_d;
  logic              pany_q, pany_d;
  logic [NSRC-1:0]   up_q, up_d;
  logic [NSRC-1:0]   dn_q, dn_d;
  logic [CNT_W-1:0]  up_pend_q [NSRC];
  logic [CNT_W-1:0]  up_pend_d [NSRC];
  logic [CNT_W-1:0]  dn_pend_q [NSRC];
  logic [CNT_W-1:0]  dn_pend_d [NSRC];

  logic [NSRC-1:0]   up_ev, dn_ev;
  logic              found, win_up, do_grant, drop, gr_up, gr_dn;
  logic [ID_W-1:0]   win, idx;
  logic [ID_W:0]     idx_sum;

  assign inc         = inc_q;
  assign dec         = dec_q;
  assign grant_id    = gid_q;
  assign pending_any = pany_q;
  assign overflow    = ovf_q;

`ifndef SCORE_ARB_FLOOR_EN
  logic unused_score_zero;
  assign unused_score_zero = score_zero;
`endif

  // A simultaneous event and grant cancel; a saturated counter drops only ungranted events.
  function automatic logic [CNT_W-1:0] next_cnt(input logic [CNT_W-1:0] cur,
                                                 input logic ev, input logic gr);
    logic [CNT_W-1:0] res;
    res = cur;
    if (ev && !gr && (cur != CNT_MAX)) res = cur + CNT_W'(1);
    else if (gr && !ev)                res = cur - CNT_W'(1);
    return res;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      rr_q      <= '0;
      gid_q     <= '0;
      inc_q     <= 1'b0;
      dec_q     <= 1'b0;
      ovf_q     <= 1'b0;
      pany_q    <= 1'b0;
      up_q      <= '0;
      dn_q      <= '0;
      up_pend_q <= '{default: '0};
      dn_pend_q <= '{default: '0};
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      gid_q     <= gid_d;
      inc_q     <= inc_d;
      dec_q     <= dec_d;
      ovf_q     <= ovf_d;
      pany_q    <= pany_d;
      up_q      <= up_d;
      dn_q      <= dn_d;
      up_pend_q <= up_pend_d;
      dn_pend_q <= dn_pend_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    gid_d     = gid_q;
    inc_d     = 1'b0;
    dec_d     = 1'b0;
    ovf_d     = ovf_q;
    pany_d    = 1'b0;
    up_pend_d = up_pend_q;
    dn_pend_d = dn_pend_q;
    up_d      = hit_up;
    dn_d      = hit_dn;
    found     = 1'b0;
    win       = '0;
    win_up    = 1'b0;
    idx       = '0;
    idx_sum   = '0;
    drop      = 1'b0;
    gr_up     = 1'b0;
    gr_dn     = 1'b0;

    up_ev = hit_up & ~up_q & {NSRC{enable}};
    dn_ev = hit_dn & ~dn_q & {NSRC{enable}};

    // Round-robin search starting at rr_q; up is served before dn within a source.
    for (int unsigned off = 0; off < NSRC; off++) begin
      idx_sum = {1'b0, rr_q} + (ID_W+1)'(off);
      if (idx_sum >= (ID_W+1)'(NSRC)) idx_sum = idx_sum - (ID_W+1)'(NSRC);
      idx = idx_sum[ID_W-1:0];
      if (!found && ((up_pend_q[idx] != '0) || (dn_pend_q[idx] != '0))) begin
        found  = 1'b1;
        win    = idx;
        win_up = (up_pend_q[idx] != '0);
      end
    end

    do_grant = (state_q == ISSUE) && enable && !flush && found;

    for (int i = 0; i < NSRC; i++) begin
      gr_up = do_grant &&  win_up && (win == ID_W'(i));
      gr_dn = do_grant && !win_up && (win == ID_W'(i));
      if (flush) begin
        up_pend_d[i] = '0;
        dn_pend_d[i] = '0;
      end else begin
        up_pend_d[i] = next_cnt(up_pend_q[i], up_ev[i], gr_up);
        dn_pend_d[i] = next_cnt(dn_pend_q[i], dn_ev[i], gr_dn);
        if ((up_ev[i] && !gr_up && (up_pend_q[i] == CNT_MAX)) ||
            (dn_ev[i] && !gr_dn && (dn_pend_q[i] == CNT_MAX))) begin
          drop = 1'b1;
        end
      end
      if ((up_pend_d[i] != '0) || (dn_pend_d[i] != '0)) pany_d = 1'b1;
    end

    if (drop)         ovf_d = 1'b1;
    else if (clr_ovf) ovf_d = 1'b0;

    if (do_grant) begin
      gid_d = win;
      rr_d  = (win == ID_W'(NSRC - 1)) ? '0 : win + ID_W'(1);
      inc_d = win_up;
`ifdef SCORE_ARB_FLOOR_EN
      dec_d = !win_up && !score_zero;
`else
      dec_d = !win_up;
`endif
    end

    case (state_q)
      IDLE:    if (enable && pany_q) state_d = ISSUE;
      ISSUE:   if (!enable || !pany_d) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_score_event_arbiter.sv
// Randomized and directed bench for score_event_arbiter against a per-cycle reference model
// holding pending counts as plain integers.
module tb_score_event_arbiter;

  localparam int NSRC  = 4;
  localparam int CNT_W = 3;
  localparam int MAXV  = (1 << CNT_W) - 1;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            enable = 1'b0;
  logic            flush = 1'b0;
  logic            score_zero = 1'b0;
  logic            clr_ovf = 1'b0;
  logic [NSRC-1:0] hit_up = '0;
  logic [NSRC-1:0] hit_dn = '0;
  logic            inc, dec, pending_any, overflow;
  logic [1:0]      grant_id;

  score_event_arbiter #(.NSRC(NSRC), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .flush      (flush),
    .hit_up     (hit_up),
    .hit_dn     (hit_dn),
    .score_zero (score_zero),
    .clr_ovf    (clr_ovf),
    .inc        (inc),
    .dec        (dec),
    .grant_id   (grant_id),
    .pending_any(pending_any),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model state
  int            m_up [NSRC];
  int            m_dn [NSRC];
  bit [NSRC-1:0] m_up_prev, m_dn_prev;
  int            m_rr, m_gid;
  bit            m_active, m_pany, m_inc, m_dec, m_ovf;

  int n_inc = 0;
  int n_dec = 0;
  int gid_log[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < NSRC; s++) begin
      m_up[s] = 0;
      m_dn[s] = 0;
    end
    m_up_prev = '0; m_dn_prev = '0;
    m_rr = 0; m_gid = 0;
    m_active = 0; m_pany = 0; m_inc = 0; m_dec = 0; m_ovf = 0;
  endtask

  // Advance the model by one clock using the current inputs.
  task automatic model_step();
    bit [NSRC-1:0] eu, ed;
    int  win;
    bit  wup, drop, any, gu, gd;
    eu = hit_up & ~m_up_prev;
    ed = hit_dn & ~m_dn_prev;
    m_up_prev = hit_up;
    m_dn_prev = hit_dn;
    win = -1; wup = 0; drop = 0; any = 0;
    if (m_active && enable && !flush) begin
      for (int k = 0; k < NSRC; k++) begin
        int s;
        s = (m_rr + k) % NSRC;
        if (win < 0 && (m_up[s] > 0 || m_dn[s] > 0)) begin
          win = s;
          wup = (m_up[s] > 0);
        end
      end
    end
    m_inc = 0; m_dec = 0;
    for (int s = 0; s < NSRC; s++) begin
      gu = (win == s) && wup;
      gd = (win == s) && !wup;
      if (flush) begin
        m_up[s] = 0;
        m_dn[s] = 0;
      end else begin
        if (enable && eu[s]) begin
          if (m_up[s] == MAXV && !gu) drop = 1; else m_up[s]++;
        end
        if (enable && ed[s]) begin
          if (m_dn[s] == MAXV && !gd) drop = 1; else m_dn[s]++;
        end
        if (gu) m_up[s]--;
        if (gd) m_dn[s]--;
      end
      if (m_up[s] > 0 || m_dn[s] > 0) any = 1;
    end
    if (win >= 0) begin
      m_gid = win;
      m_rr  = (win + 1) % NSRC;
      m_inc = wup;
`ifdef SCORE_ARB_FLOOR_EN
      m_dec = !wup && !score_zero;
`else
      m_dec = !wup;
`endif
    end
    if (!m_active) m_active = enable && m_pany;
    else           m_active = enable && any;
    m_pany = any;
    if (drop)         m_ovf = 1;
    else if (clr_ovf) m_ovf = 0;
  endtask

  task automatic compare();
    check("inc", inc, m_inc);
    check("dec", dec, m_dec);
    check("grant_id", grant_id, m_gid);
    check("pending_any", pending_any, m_pany);
    check("overflow", overflow, m_ovf);
    if (inc) n_inc++;
    if (dec) n_dec++;
    if (inc || dec) gid_log.push_back(int'(grant_id));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic idle_inputs();
    hit_up = '0; hit_dn = '0;
    enable = 0; flush = 0; clr_ovf = 0; score_zero = 0;
  endtask

  // Asserts reset away from a clock edge and checks that outputs clear at once.
  task automatic apply_reset(input string tag);
    idle_inputs();
    #2;
    reset = 1'b1;
    #1;
    check({tag, "_inc"}, inc, 0);
    check({tag, "_dec"}, dec, 0);
    check({tag, "_gid"}, grant_id, 0);
    check({tag, "_pany"}, pending_any, 0);
    check({tag, "_ovf"}, overflow, 0);
    #1;
    reset = 1'b0;
    model_reset();
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, exp_dec;
    int exp_order[3];
    exp_order[0] = 0; exp_order[1] = 1; exp_order[2] = 3;

    model_reset();
    apply_reset("rst");

    // Single event: one inc from source 2, three edges after the rise
    enable = 1;
    tick();
    base = n_inc;
    hit_up = 4'b0100;
    tick(); tick(); tick();
    check("single_inc", inc, 1);
    check("single_gid", grant_id, 2);
    for (int c = 0; c < 4; c++) tick();
    check("single_count", n_inc - base, 1);
    check("single_pany", pending_any, 0);

    // Round-robin order from a fresh pointer, twice
    apply_reset("rst_rr");
    enable = 1;
    for (int r = 0; r < 2; r++) begin
      hit_up = '0; hit_dn = '0;
      tick();
      gid_log.delete();
      hit_up = 4'b1001; hit_dn = 4'b0010;
      for (int c = 0; c < 7; c++) tick();
      check("rr_len", gid_log.size(), 3);
      for (int k = 0; k < 3 && k < gid_log.size(); k++) check("rr_order", gid_log[k], exp_order[k]);
    end

    // Saturation: every source toggles faster than the arbiter can drain
    apply_reset("rst_sat");
    enable = 1;
    for (int c = 0; c < 24; c++) begin
      hit_up = (c % 2 == 0) ? 4'hF : 4'h0;
      hit_dn = hit_up;
      tick();
    end
    check("sat_ovf", overflow, 1);
    hit_up = '0; hit_dn = '0;
    clr_ovf = 1;
    tick();
    clr_ovf = 0;
    check("ovf_clr", overflow, 0);
    for (int c = 0; c < 80 && pending_any; c++) tick();
    check("sat_drain", pending_any, 0);

    // Enable gating and flush
    apply_reset("rst_en");
    enable = 1;
    base = n_inc;
    hit_up = 4'b0111;
    tick(); tick(); tick();
    check("en_first", inc, 1);
    enable = 0;
    for (int c = 0; c < 3; c++) tick();
    check("en_stop", n_inc - base, 1);
    check("en_hold_pany", pending_any, 1);
    flush = 1;
    tick();
    flush = 0;
    check("flush_pany", pending_any, 0);
    enable = 1;
    for (int c = 0; c < 5; c++) tick();
    check("flush_nopulse", n_inc - base, 1);

    // Floor behaviour with score_zero high, then low
`ifdef SCORE_ARB_FLOOR_EN
    exp_dec = 0;
`else
    exp_dec = 1;
`endif
    hit_up = '0;
    score_zero = 1;
    base = n_dec;
    hit_dn = 4'b0001;
    for (int c = 0; c < 5; c++) tick();
    check("floor_zero_dec", n_dec - base, exp_dec);
    check("floor_zero_pany", pending_any, 0);
    hit_dn = '0;
    tick();
    score_zero = 0;
    base = n_dec;
    hit_dn = 4'b0001;
    for (int c = 0; c < 5; c++) tick();
    check("floor_nz_dec", n_dec - base, 1);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      hit_up = hit_up ^ 4'($urandom_range(0, 15) & $urandom_range(0, 15));
      hit_dn = hit_dn ^ 4'($urandom_range(0, 15) & $urandom_range(0, 15));
      enable = ($urandom_range(0, 9) != 0);
      flush = ($urandom_range(0, 49) == 0);
      clr_ovf = ($urandom_range(0, 19) == 0);
      score_zero = ($urandom_range(0, 2) == 0);
      tick();
    end

    // Async reset in the middle of a burst discards everything pending
    apply_reset("rst_pre");
    enable = 1;
    hit_up = 4'hF;
    tick();
    check("burst_pany", pending_any, 1);
    apply_reset("rst_mid");
    enable = 1;
    base = n_inc + n_dec;
    for (int c = 0; c < 8; c++) tick();
    check("post_rst_pulses", n_inc + n_dec - base, 0);
    check("post_rst_pany", pending_any, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
